thermo_conv_scheduler: RTL and testbench

THERMO_CONV_SCHEDULER -- requirements
Module: thermo_conv_scheduler

---
 rtl/thermo_conv_scheduler.sv | 102 ++++++++++
 tb/tb_thermo_conv_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/thermo_conv_scheduler.sv
// thermo_conv_scheduler: converts a batch of thermometer words, one lane per cycle, into signed codes and their sum
module thermo_conv_scheduler #(
   parameter int N_LANES = 8,
   parameter int WIDTH   = 64,
   parameter int CODE_W  = $clog2(WIDTH) + 1,
   parameter int ACC_W   = CODE_W + $clog2(N_LANES)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [N_LANES*WIDTH-1:0]    in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [N_LANES*CODE_W-1:0]   out_lane_vals,
   output logic [N_LANES-1:0]          out_empty_mask,
   output logic [ACC_W-1:0]            out_sum,
   output logic                        busy
);
   localparam int CNT_W = N_LANES > 1 ? $clog2(N_LANES) : 1;
   localparam int IDX_W = CODE_W - 1;
   localparam logic signed [CODE_W-1:0] OFFSET = CODE_W'(2 ** (CODE_W - 2));

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t                      state, state_nxt;
   logic [N_LANES*WIDTH-1:0]    batch;
   logic [CNT_W-1:0]            lane_cnt;
   logic signed [ACC_W-1:0]     acc;
   logic [N_LANES-1:0]          mask;
   logic [N_LANES*CODE_W-1:0]   lane_vals;
   logic [WIDTH-1:0]            enc_word;
   logic [IDX_W-1:0]            enc_idx;
   logic                        enc_hit;
   logic signed [CODE_W-1:0]    enc_code;
   logic                        accept;
   logic                        last_lane;

   assign in_ready       = state == IDLE && !flush;
   assign accept         = in_valid && in_ready;
   assign last_lane      = lane_cnt == CNT_W'(N_LANES - 1);
   assign busy           = state != IDLE;
   assign out_valid      = state == DONE;
   assign out_lane_vals  = out_valid ? lane_vals : '0;
   assign out_empty_mask = out_valid ? mask : '0;
   assign out_sum        = out_valid ? acc : '0;

   // shared encoder: highest set bit of the current lane, idle (all zero) outside CONV
   always_comb begin
      enc_word = state == CONV ? batch[lane_cnt*WIDTH +: WIDTH] : '0;
      enc_idx  = '0;
      enc_hit  = 1'b0;
      for (int i = 0; i < WIDTH; i++)
         if (enc_word[i]) begin
            enc_idx = IDX_W'(i);
            enc_hit = 1'b1;
         end
      enc_code = enc_hit ? signed'({1'b0, enc_idx}) - OFFSET : '0;
   end

   // next state; flush overrides everything and forces IDLE
   always_comb begin
      state_nxt = flush         ? IDLE :
                  state == IDLE ? (in_valid ? CONV : IDLE) :
                  state == CONV ? (last_lane ? DONE : CONV) :
                                  (out_ready ? IDLE : DONE);
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // batch capture and per-lane accumulation of codes, mask and sum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         batch     <= '0;
         lane_cnt  <= '0;
         acc       <= '0;
         mask      <= '0;
         lane_vals <= '0;
      end else if (flush) begin
         lane_cnt  <= '0;
         acc       <= '0;
         mask      <= '0;
         lane_vals <= '0;
      end else if (accept) begin
         batch     <= in_data;
         lane_cnt  <= '0;
         acc       <= '0;
         mask      <= '0;
         lane_vals <= '0;
      end else if (state == CONV) begin
         lane_vals[lane_cnt*CODE_W +: CODE_W] <= enc_code;
         mask[lane_cnt]                       <= !enc_hit;
         acc                                  <= acc + ACC_W'(enc_code);
         lane_cnt                             <= lane_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_thermo_conv_scheduler.sv
// tb_thermo_conv_scheduler: table-driven and scoreboard checks of the thermometer batch converter
module tb_thermo_conv_scheduler;
   localparam int N = 8, W = 64, C = 7, A = 10;

   logic             clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [N*W-1:0]   in_data = '0;
   logic             in_ready, out_valid, busy;
   logic [N*C-1:0]   out_lane_vals;
   logic [N-1:0]     out_empty_mask;
   logic [A-1:0]     out_sum;

   typedef struct {
      logic [N*W-1:0] data;
      logic [N*C-1:0] vals;
      logic [N-1:0]   mask;
      logic [A-1:0]   sum;
   } rec_t;

   rec_t tbl[7];
   rec_t q[$];
   int   n_cmp = 0, n_fail = 0;

   thermo_conv_scheduler dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_lane_vals(out_lane_vals), .out_empty_mask(out_empty_mask), .out_sum(out_sum), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic rec_t mk(input logic [W-1:0] w, input logic [N-1:0] z,
                               input logic [C-1:0] c, input logic [A-1:0] s);
      rec_t r;
      r.mask = z;
      r.sum  = s;
      for (int k = 0; k < N; k++) begin
         r.data[k*W +: W] = z[k] ? '0 : w;
         r.vals[k*C +: C] = z[k] ? '0 : c;
      end
      return r;
   endfunction

   function automatic rec_t model(input logic [N*W-1:0] d);
      rec_t r;
      int   s = 0;
      r.data = d;
      r.vals = '0;
      r.mask = '0;
      for (int k = 0; k < N; k++) begin
         int top = -1;
         for (int b = W - 1; b >= 0; b--)
            if (d[k*W + b]) begin
               top = b;
               break;
            end
         if (top < 0) r.mask[k] = 1'b1;
         else begin
            r.vals[k*C +: C] = C'(top - 32);
            s += top - 32;
         end
      end
      r.sum = A'(s);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
   endtask

   task automatic accept(input logic [N*W-1:0] d);
      int t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("in_ready_before_accept", in_ready, 1);
      if (!in_ready) begin
         summary();
         $fatal(1, "input handshake never opened");
      end
      in_data  = d;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("busy_after_accept", busy, 1);
   endtask

   task automatic drain(input int hold);
      int   lat = 0;
      rec_t e;
      chk("conv_sum_zero", 64'(out_sum), 0);
      chk("conv_vals_zero", 64'(out_lane_vals), 0);
      while (!out_valid && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, 8);
      if (!out_valid || q.size() == 0) begin
         chk("scoreboard_ready", q.size(), 1);
         summary();
         $fatal(1, "no result to compare");
      end
      e = q.pop_front();
      repeat (hold) begin
         chk("hold_vals", 64'(out_lane_vals), 64'(e.vals));
         chk("hold_sum", 64'(out_sum), 64'(e.sum));
         chk("hold_in_ready", in_ready, 0);
         @(negedge clk);
      end
      chk("vals", 64'(out_lane_vals), 64'(e.vals));
      chk("mask", 64'(out_empty_mask), 64'(e.mask));
      chk("sum", 64'(out_sum), 64'(e.sum));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("idle_after_ready", {out_valid, busy, in_ready}, 3'b001);
   endtask

   task automatic no_valid(input string nm);
      int seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk(nm, seen, 0);
   endtask

   task automatic run(input rec_t r, input int hold);
      q.push_back(r);
      accept(r.data);
      drain(hold);
   endtask

   function automatic logic [N*W-1:0] rand_batch();
      logic [N*W-1:0] d;
      for (int k = 0; k < N; k++) begin
         int          p = $urandom_range(0, W);
         logic [63:0] noise = {$urandom, $urandom};
         logic [63:0] one = 64'd1;
         d[k*W +: W] = p == W ? '0 : (noise & ((one << p) - 1)) | (one << p);
      end
      return d;
   endfunction

   initial begin
      tbl[0] = mk(64'h0000_0100_0000_0000, 8'h00, 7'd8,   10'd64);
      tbl[1] = mk('1,                      8'h00, 7'd31,  10'd248);
      tbl[2] = mk(64'h1,                   8'h00, 7'h60,  10'h300);
      tbl[3] = mk(64'h8000_0000_0000_0000, 8'b0010_0100, 7'd31, 10'd186);
      tbl[4] = mk(64'h0,                   8'hFF, 7'd0,   10'd0);
      tbl[5] = mk(64'h0000_0001_FFFF_0000, 8'h00, 7'd0,   10'd0);
      tbl[6] = mk(64'h0000_0000_8000_1234, 8'h00, 7'h7F,  10'h3F8);

      #2;
      chk("rst_state", {in_ready, out_valid, busy}, 3'b100);
      chk("rst_outputs", {8'(out_empty_mask), 10'(out_sum), 56'(out_lane_vals)}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run(tbl[i], i == 0 ? 5 : 0);
      for (int i = 0; i < 3; i++) run(model(rand_batch()), 0);

      accept(tbl[1].data);
      repeat (3) @(negedge clk);
      flush = 1'b1;
      #1 chk("flush_conv_in_ready", in_ready, 0);
      @(negedge clk);
      flush = 1'b0;
      chk("flush_conv_idle", {busy, out_valid, 10'(out_sum)}, 0);
      no_valid("flush_conv_no_valid");

      in_data  = tbl[0].data;
      in_valid = 1'b1;
      flush    = 1'b1;
      #1 chk("flush_idle_in_ready", in_ready, 0);
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_idle_not_busy", busy, 0);
      no_valid("flush_idle_no_valid");

      run(tbl[3], 0);

      accept(tbl[1].data);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("rst_conv_state", {in_ready, out_valid, busy, 10'(out_sum)}, 13'h1000);
      @(negedge clk);
      rst_n = 1'b1;
      no_valid("rst_conv_no_valid");

      accept(tbl[1].data);
      repeat (8) @(negedge clk);
      chk("rst_done_pre_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1 chk("rst_done_outputs", {out_valid, busy, 8'(out_empty_mask), 10'(out_sum), 56'(out_lane_vals)}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      no_valid("rst_done_no_valid");

      run(tbl[2], 2);
      chk("queue_empty", q.size(), 0);
      summary();
      $finish;
   end
endmodule
